// File: rtl/ethernet_tx_arbiter.sv
// Merges NUM_CH AXI-Stream reply sources onto one TX stream with frame-atomic
// fixed-priority or round-robin arbitration and MAX_BEATS frame truncation.
module ethernet_tx_arbiter #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ARB_MODE  = 1,
    parameter int unsigned MAX_BEATS = 190
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_CH-1:0]              i_s_axis_tvalid,
    input  logic [NUM_CH*DATA_W-1:0]       i_s_axis_tdata,
    input  logic [NUM_CH-1:0]              i_s_axis_tlast,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   i_s_axis_tkeep,
    output logic [NUM_CH-1:0]              o_s_axis_tready,
    output logic                           o_m_axis_tvalid,
    output logic [DATA_W-1:0]              o_m_axis_tdata,
    output logic                           o_m_axis_tlast,
    output logic [(DATA_W/8)-1:0]          o_m_axis_tkeep,
    input  logic                           i_m_axis_tready,
    output logic                           o_busy,
    output logic [2:0]                     o_grant_ch,
    output logic                           o_frame_done,
    output logic                           o_truncated
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 12;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               trunc_q, trunc_d;

    logic               pick_found;
    logic [2:0]         pick;
    int unsigned        cand;
    logic [NUM_CH-1:0]  grant_oh;
    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic [KEEP_W-1:0]  sel_keep;
    logic               at_max;
    logic               beat_acc;
    logic [2:0]         rr_after;

    // Arbitration: scan upward from rr_ptr (round-robin) or from 0 (fixed)
    always_comb begin
        pick_found = 1'b0;
        pick       = 3'd0;
        cand       = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cand = (ARB_MODE == 1) ? 32'(rr_ptr_q) + 32'(i) : 32'(i);
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (!pick_found && (32'(k) == cand) && i_s_axis_tvalid[k]) begin
                    pick_found = 1'b1;
                    pick       = 3'(k);
                end
            end
        end
    end

    // Granted-channel mux
    always_comb begin
        grant_oh  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (grant_q == 3'(k)) begin
                grant_oh[k] = 1'b1;
                sel_valid   = i_s_axis_tvalid[k];
                sel_last    = i_s_axis_tlast[k];
                sel_data    = i_s_axis_tdata[k*DATA_W +: DATA_W];
                sel_keep    = i_s_axis_tkeep[k*KEEP_W +: KEEP_W];
            end
        end
    end

    assign at_max   = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    assign rr_after = (grant_q == 3'(NUM_CH - 1)) ? 3'd0 : grant_q + 3'd1;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            grant_q    <= 3'd0;
            rr_ptr_q   <= 3'd0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            trunc_q    <= trunc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        beat_cnt_d      = beat_cnt_q;
        done_d          = 1'b0;
        trunc_d         = 1'b0;
        beat_acc        = 1'b0;
        o_s_axis_tready = '0;
        o_m_axis_tvalid = 1'b0;
        o_m_axis_tdata  = '0;
        o_m_axis_tlast  = 1'b0;
        o_m_axis_tkeep  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                o_m_axis_tvalid = sel_valid;
                o_m_axis_tdata  = sel_data;
                o_m_axis_tkeep  = sel_keep;
                // Beat MAX_BEATS closes the frame even without a source tlast
                o_m_axis_tlast  = sel_last | at_max;
                o_s_axis_tready = i_m_axis_tready ? grant_oh : '0;
                beat_acc        = sel_valid & i_m_axis_tready;
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (sel_last) begin
                        done_d   = 1'b1;
                        rr_ptr_d = rr_after;
                        state_d  = S_IDLE;
                    end else if (at_max) begin
                        done_d   = 1'b1;
                        trunc_d  = 1'b1;
                        rr_ptr_d = rr_after;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                o_s_axis_tready = grant_oh;
                if (sel_valid && sel_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign o_busy       = busy_q;
    assign o_grant_ch   = grant_q;
    assign o_frame_done = done_q;
    assign o_truncated  = trunc_q;

endmodule
